// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton event decoder: state encoding and
// bit positions of the packed event bus.
package pb_pkg;

   typedef enum logic [2:0] {
      ARM    = 3'd0,
      IDLE   = 3'd1,
      PRESS1 = 3'd2,
      LONG   = 3'd3,
      GAP    = 3'd4,
      PRESS2 = 3'd5
   } pb_state_e;

   localparam int unsigned EV_PRESS   = 0;
   localparam int unsigned EV_RELEASE = 1;
   localparam int unsigned EV_SHORT   = 2;
   localparam int unsigned EV_LONG    = 3;
   localparam int unsigned EV_DOUBLE  = 4;
   localparam int unsigned EV_W       = 5;

endpackage

// File: rtl/pb_event_timer.sv
// Loadable up-counter shared between hold and gap timing; match flags that the
// next increment would reach the limit.
module pb_event_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_p,
   input  logic             load,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             match
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   cnt_inc;

   // One extra bit so the compare cannot alias on overflow.
   assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign match   = (cnt_inc == {1'b0, limit});

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CNT_W'(1);
      end else if (inc) begin
         cnt_q <= cnt_inc[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/pb_event_decoder.sv
// Classifies a debounced button level into registered single-cycle events:
// press, release, short, long and double press.
module pb_event_decoder
   import pb_pkg::*;
#(
   parameter logic        ACTIVE_LEVEL = 1'b1,
   parameter int unsigned LONG_CYCLES  = 100,
   parameter int unsigned DOUBLE_GAP   = 30,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_p,
   input  logic pb_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic double_press,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DOUBLE_GAP);

   pb_state_e        state_q, state_d;
   logic [EV_W-1:0]  ev_q, ev_d;
   logic             held_q, held_d;
   logic             act;
   logic             tmr_load, tmr_inc, tmr_match;
   logic [CNT_W-1:0] tmr_limit;

   assign act = (pb_level == ACTIVE_LEVEL);

   pb_event_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_p (rst_p),
      .load  (tmr_load),
      .inc   (tmr_inc),
      .limit (tmr_limit),
      .match (tmr_match)
   );

   always_comb begin
      state_d   = state_q;
      ev_d      = '0;
      tmr_load  = 1'b0;
      tmr_inc   = 1'b0;
      tmr_limit = (state_q == GAP) ? GAP_LIM : LONG_LIM;
      // ARM masks a button held through reset until it is first seen released.
      held_d    = (state_q != ARM) && act;

      case (state_q)
         ARM: begin
            if (!act) state_d = IDLE;
         end
         IDLE: begin
            if (act) begin
               state_d        = PRESS1;
               tmr_load       = 1'b1;
               ev_d[EV_PRESS] = 1'b1;
            end
         end
         PRESS1: begin
            if (act) begin
               if (tmr_match) begin
                  state_d       = LONG;
                  ev_d[EV_LONG] = 1'b1;
               end else begin
                  tmr_inc = 1'b1;
               end
            end else begin
               state_d          = GAP;
               tmr_load         = 1'b1;
               ev_d[EV_RELEASE] = 1'b1;
            end
         end
         LONG: begin
            if (!act) begin
               state_d          = IDLE;
               ev_d[EV_RELEASE] = 1'b1;
            end
         end
         GAP: begin
            if (act) begin
               state_d         = PRESS2;
               ev_d[EV_PRESS]  = 1'b1;
               ev_d[EV_DOUBLE] = 1'b1;
            end else if (tmr_match) begin
               state_d        = IDLE;
               ev_d[EV_SHORT] = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         PRESS2: begin
            if (!act) begin
               state_d          = IDLE;
               ev_d[EV_RELEASE] = 1'b1;
            end
         end
         default: state_d = ARM;
      endcase
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         state_q <= ARM;
         ev_q    <= '0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ev_q    <= ev_d;
         held_q  <= held_d;
      end
   end

   assign press_pulse   = ev_q[EV_PRESS];
   assign release_pulse = ev_q[EV_RELEASE];
   assign short_press   = ev_q[EV_SHORT];
   assign long_press    = ev_q[EV_LONG];
   assign double_press  = ev_q[EV_DOUBLE];
   assign held          = held_q;

endmodule

// File: doc/pb_event_decoder.md
Name: pb_event_decoder

Overview:
- Consumer end of the pushbutton debounce path: takes an already-debounced button level and classifies presses into single-cycle event pulses (press, release, short, long, double).
- Sits between the debouncer and the lab FSMs (counter/stopwatch mode and start/stop logic), all on the same slow clk domain.
- Replaces ad-hoc one-pulse logic in each top level.

Parameters:
- ACTIVE_LEVEL, 1, level of pb_level meaning "button pressed".
- LONG_CYCLES, 100, consecutive active samples that make a long press; must be >= 2.
- DOUBLE_GAP, 30, max consecutive inactive samples between two presses for a double press; must be >= 2.
- CNT_W, 8, counter width; must hold max(LONG_CYCLES, DOUBLE_GAP).

Ports:
- clk  input  1  sampling clock (debouncer clock).
- rst_p  input  1  reset, asynchronous, active-high.
- pb_level  input  1  debounced button level, synchronous to clk.
- press_pulse  output  1  one cycle on each accepted inactive->active transition.
- release_pulse  output  1  one cycle on each accepted active->inactive transition.
- short_press  output  1  one cycle: single press that was neither long nor followed by a second press.
- long_press  output  1  one cycle when the hold reaches LONG_CYCLES.
- double_press  output  1  one cycle when the second press of a pair starts.
- held  output  1  registered "pressed" level; 0 while disarmed.

Behaviour:
- Reset is rst_p, asynchronous, active-high; clock is clk. All outputs reset to 0, cnt = 0, state = ARM.
- act = (pb_level == ACTIVE_LEVEL), sampled at each posedge.
- All outputs are registered. An event detected on the sample taken at edge k is high for exactly the cycle after edge k.
- States:
  - ARM: no events emitted; held = 0. First !act sample -> IDLE. This guards against the debouncer's reset value of 1 and a button held through reset.
  - IDLE: act -> PRESS1, cnt = 1, press_pulse.
  - PRESS1, act: if cnt+1 == LONG_CYCLES -> LONG and long_press; otherwise cnt++.
  - PRESS1, !act: -> GAP, cnt = 1, release_pulse.
  - LONG: act -> stay, no further events. !act -> IDLE, release_pulse. Never emits short or double.
  - GAP, act: -> PRESS2, press_pulse and double_press in the same cycle.
  - GAP, !act: if cnt+1 == DOUBLE_GAP -> IDLE and short_press; otherwise cnt++.
  - PRESS2: no long detection. !act -> IDLE, release_pulse.
- held = act registered in all states except ARM.
- Each event is at most one cycle wide. Events never repeat without a new transition.
- Counter never exceeds the active threshold; no wrap-around is possible.
- Boundary cases:
  - Press of exactly LONG_CYCLES-1 samples is short (or first of a double).
  - Gap of exactly DOUBLE_GAP-1 inactive samples still yields a double.
  - Gap of DOUBLE_GAP samples yields short_press; a press on the next sample is a new first press.
- Reset mid-operation: immediate return to ARM with all pulses cleared. A pending short_press is discarded.

Decomposition:
- Shared package pb_pkg: state encoding localparams (ARM, IDLE, PRESS1, LONG, GAP, PRESS2; 3-bit), event bit indices for an optional packed event bus.
- One sub-module is natural: pb_event_timer, a loadable up-counter with a match flag, instanced once and shared between hold timing and gap timing.

Test Plan:
Bench uses LONG_CYCLES=8, DOUBLE_GAP=4.
1. Reset with pb_level=1 held 20 cycles -> no events, held=0. Then 0 for 2 cycles, 1 for 3 cycles -> press_pulse 1 cycle after first 1, held=1.
2. Press 3 samples, release 4+ samples -> press_pulse, release_pulse, then short_press exactly 1 cycle after the 4th inactive sample. No double or long.
3. Press 10 samples -> long_press 1 cycle after the 8th active sample. Release -> release_pulse only, no short_press.
4. Press 2, release 3, press 2 -> double_press with the second press_pulse. Release -> release_pulse. No short_press afterwards.
5. Press 7 samples -> no long_press. Release 4 -> short_press. Press 2, release 3, press 1 (gap = DOUBLE_GAP-1) -> double_press.
6. Assert rst_p in GAP after 2 inactive samples -> all outputs 0 immediately, no short_press afterwards. Then pb_level=1 after reset -> no press until a 0 sample has been seen.
